uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Serial receive front end for the cpu: deserialises 8-bit UART frames arriving on RsRx and
//  buffers them in a small FIFO. The cpu core pops bytes through a valid/ready handshake.
//  Sits between the board RsRx pin and the cpu's monitor/command path.
//  All logic runs in the single clk domain.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  BAUD        115200       serial bit rate
//  OVERSAMPLE  16           sample ticks per bit; must be even and >= 4
//  FIFO_DEPTH  8            FIFO entries; must be a power of 2, >= 2
// PORTS
//  clk        in   1                     system clock, rising edge
//  resetn     in   1                     asynchronous active-low reset
//  RsRx       in   1                     serial input, idle high, asynchronous to clk
//  rx_data    out  8                     FIFO head byte; valid only while rx_valid=1
//  rx_valid   out  1                     FIFO not empty
//  rx_ready   in   1                     consumer accepts head byte
//  rx_count   out  $clog2(FIFO_DEPTH)+1  bytes currently held
//  frame_err  out  1                     1-clk pulse: stop bit sampled low
//  overrun    out  1                     1-clk pulse: complete byte dropped because FIFO was full
//  parity_err out  1                     1-clk pulse: parity mismatch; tied 0 unless UART_RX_PARITY_EN
// BEHAVIOUR
//  Reset (resetn=0, async), all outputs 0:
//   - rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun=0, parity_err=0.
//   - FSM=IDLE, FIFO pointers=0, tick counter=0, synchroniser flops=1.
//  Reset mid-frame discards the partial byte and all FIFO contents.
//  Input path:
//   - RsRx passes through a 2-flop synchroniser (reset value 1); the FSM sees only the synchronised bit.
//  Tick generator:
//   - DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation; DIV<1 is forced to 1.
//   - Counter runs 0..DIV-1 and pulses tick on DIV-1; it runs freely and is not re-phased.
//  FSM (advances only on tick, except the IDLE line check):
//   IDLE     sync=0 -> START; clear sample counter.
//   START    at sample OVERSAMPLE/2-1 (mid-bit): sync=0 -> DATA; sync=1 -> IDLE (glitch reject).
//   DATA     sample every OVERSAMPLE ticks, LSB first, into a shift reg; after bit 7 -> STOP.
//            With UART_RX_PARITY_EN the next state is PARITY instead of STOP.
//   PARITY   sample one bit -> STOP.
//   STOP     mid-bit sample. sync=1 -> push byte, go IDLE.
//            sync=0 -> frame_err pulse, drop byte, go WAIT_HI.
//   WAIT_HI  stay until sync=1 (break/line-low), then IDLE. Prevents re-triggering on a held-low line.
//  FIFO (first-word-fall-through):
//   - rx_valid = (count!=0); rx_data = mem[rd_ptr], registered head.
//   - Pop when rx_valid & rx_ready; rx_ready while empty is ignored.
//   - Push latency: rx_valid rises 1 clk after the clk carrying the STOP mid-bit tick.
//   - Full + push, no pop: byte dropped, overrun pulses, contents unchanged.
//   - Full + push + pop same clk: both happen; count stays FIFO_DEPTH; no overrun.
//   - Empty + push: no same-clk pop; count 0->1.
//   - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
//  Error outputs:
//   - Pulses last exactly one clk; a rejected frame is never pushed.
//   - Frame and parity errors on one frame: parity_err and frame_err fire on the STOP tick, both set.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - Frame is 8E1: the even-parity bit after the data bits is checked.
//   - Mismatch: parity_err pulses at STOP and the byte is dropped, even if the stop bit is good.
//  UART_RX_PARITY_EN undefined:
//   - Frame is 8N1; PARITY state is absent; parity_err is tied 0.
// TESTING  (CLK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
//  1 Send 8N1 0xA5 -> rx_valid=1, rx_data=A5, rx_count=1; one-clk rx_ready -> rx_valid=0, count=0.
//  2 Pulse RsRx low for 30 clk, then idle -> START rejects it; count stays 0, no error pulse.
//  3 Send 0x3C with the stop bit low for one bit, then high -> frame_err pulses once; count=0.
//    Next byte 0x11 is received correctly.
//  4 Send 0x00..0x08 back-to-back, rx_ready=0 -> count=8, one overrun on the 9th byte.
//    Popping 8 times then yields 00..07 in order.
//  5 Drop resetn low after 4 data bits of 0xFF while holding 3 bytes -> outputs 0 immediately.
//    After release, 0x5A is received as the only byte.
//  6 With UART_RX_PARITY_EN: send 0x07 with parity=0 -> parity_err pulse, count=0.
//    0x07 with parity=1 -> rx_data=07.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through byte FIFO popped through a valid/ready handshake.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          RsRx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  MID_SAMPLE  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  LAST_SAMPLE = OS_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HI
    } state_e;

    logic [DIV_W-1:0] divCnt_q;
    logic             tick;
    logic             sync1_q, sync2_q;
    logic             rxSync;

    state_e           state_q, state_d;
    logic [OS_W-1:0]  sampleCnt_q, sampleCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic             parityBit_q, parityBit_d;
    logic             parityErr_q, parityErr_d;
`endif
    logic             frameErr_q, frameErr_d;
    logic             overrun_q;
    logic             pushReq;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, pop, doPush;

    // Free-running sample tick; never re-phased to the incoming edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            divCnt_q <= '0;
        end else if (divCnt_q == DIV_LAST) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
        end
    end

    assign tick = (divCnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RsRx;
            sync2_q <= sync1_q;
        end
    end

    assign rxSync = sync2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
            parityBit_q <= parityBit_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    // Only the idle line check runs every clock; all bit sampling waits for tick.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        frameErr_d  = 1'b0;
        pushReq     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBit_d = parityBit_q;
        parityErr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxSync) begin
                    state_d     = START;
                    sampleCnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (sampleCnt_q == MID_SAMPLE) begin
                        sampleCnt_d = '0;
                        bitCnt_d    = '0;
                        state_d     = rxSync ? IDLE : DATA;
                    end else begin
                        sampleCnt_d = sampleCnt_q + OS_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sampleCnt_q == LAST_SAMPLE) begin
                        sampleCnt_d = '0;
                        shift_d     = {rxSync, shift_q[7:1]};
                        bitCnt_d    = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + OS_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sampleCnt_q == LAST_SAMPLE) begin
                        sampleCnt_d = '0;
                        parityBit_d = rxSync;
                        state_d     = STOP;
                    end else begin
                        sampleCnt_d = sampleCnt_q + OS_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (sampleCnt_q == LAST_SAMPLE) begin
                        sampleCnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        parityErr_d = (parityBit_q != (^shift_q));
                        pushReq     = rxSync && (parityBit_q == (^shift_q));
`else
                        pushReq     = rxSync;
`endif
                        if (rxSync) begin
                            state_d = IDLE;
                        end else begin
                            frameErr_d = 1'b1;
                            state_d    = WAIT_HI;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + OS_W'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (tick && rxSync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop    = rx_valid && rx_ready;
    assign full   = (count_q == FULL_COUNT);
    assign doPush = pushReq && (!full || pop);

    // A push into a full FIFO only succeeds when the head is popped in the same clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            overrun_q <= pushReq && full && !pop;
            if (doPush) begin
                mem_q[wrPtr_q] <= shift_q;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (doPush && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!doPush && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign rx_data   = mem_q[rdPtr_q];
    assign rx_valid  = (count_q != '0);
    assign rx_count  = count_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parityErr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
